// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller: the
// controller state encoding and the constant operand used to leave the
// Montgomery domain.
package modexp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV_X,
    SQ,
    MUL,
    CONV_OUT,
    DONE
  } state_e;

  // Multiplying by plain 1 in Montgomery form strips the R factor.
  localparam int unsigned MM_ONE = 1;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M on top of
// an external Montgomery multiplier. Operands enter the Montgomery domain in
// CONV_X and leave it in CONV_OUT, so callers only see plain integers.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int CW        = $clog2(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH:0]       mm_result,
  input  logic                 mm_done
);

  state_e               state_q, state_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     xt_q, xt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     mm_a_q, mm_a_d;
  logic [WIDTH-1:0]     mm_b_q, mm_b_d;
  logic                 mm_start_q, mm_start_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     prod;
  logic                 prod_valid;
  logic                 take_next;
  logic                 unused_mm_msb;

  // The multiplier keeps its product below M, so the top bit carries nothing.
  assign prod          = mm_result[WIDTH-1:0];
  assign unused_mm_msb = mm_result[WIDTH];

  // A completion is only meaningful once our start pulse has been retired.
  assign prod_valid = mm_done & ~mm_start_q;

  // Next-state, operand and counter computation for the square/multiply sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    e_d        = e_q;
    m_d        = m_q;
    acc_d      = acc_q;
    xt_d       = xt_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_start_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    take_next  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          e_d        = in_e;
          m_d        = in_m;
          acc_d      = in_r;
          xt_d       = '0;
          mm_a_d     = in_x;
          mm_b_d     = in_r2;
          mm_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = CONV_X;
        end
      end
      CONV_X: begin
        if (prod_valid) begin
          xt_d       = prod;
          idx_d      = CW'(EXP_WIDTH - 1);
          mm_a_d     = acc_q;
          mm_b_d     = acc_q;
          mm_start_d = 1'b1;
          state_d    = SQ;
        end
      end
      SQ: begin
        if (prod_valid) begin
          acc_d = prod;
          if (e_q[idx_q]) begin
            mm_a_d     = prod;
            mm_b_d     = xt_q;
            mm_start_d = 1'b1;
            state_d    = MUL;
          end else begin
            take_next = 1'b1;
          end
        end
      end
      MUL: begin
        if (prod_valid) begin
          acc_d     = prod;
          take_next = 1'b1;
        end
      end
      CONV_OUT: begin
        if (prod_valid) begin
          result_d = prod;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The per-bit NEXT decision happens on the same edge that captures the
    // product, launching either the following square or the exit conversion.
    if (take_next) begin
      mm_a_d     = prod;
      mm_start_d = 1'b1;
      if (idx_q == '0) begin
        mm_b_d  = WIDTH'(MM_ONE);
        state_d = CONV_OUT;
      end else begin
        idx_d   = idx_q - 1'b1;
        mm_b_d  = prod;
        state_d = SQ;
      end
    end
  end

  // State and registered outputs; reset returns to IDLE with no pending pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      e_q        <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      xt_q       <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      e_q        <= e_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      xt_q       <= xt_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule
